fltadd_seq: RTL

//  Hardware sequencer for half-precision (1/5/10) float addition using data memory.
//  It owns the data-memory port for one run and reads two operands at BASE_ADDR..+3
//  (MSB first). It aligns and adds them, then writes the sum to BASE_ADDR+4/+5.

---
 rtl/fltadd_pkg.sv | 33 +++
 rtl/fltadd_align.sv | 48 ++++
 rtl/fltadd_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fltadd_pkg.sv
// Shared types and helpers for the half-precision add sequencer.
package fltadd_pkg;

  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

  typedef enum logic [2:0] {
    IDLE, READ, ALIGN, ADD, WR_HI, WR_LO, DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] frac;
  } hp_t;

  // Raw 16-bit word to fields.
  function automatic hp_t unpack(input logic [15:0] w);
    return hp_t'(w);
  endfunction

  // Significand with hidden bit; denormal/zero exponent gives hidden bit 0.
  function automatic logic [MANT_W:0] mant(input hp_t f);
    return {|f.exp, f.frac};
  endfunction

  // Fields back to a raw 16-bit word.
  function automatic logic [15:0] pack(input hp_t f);
    return 16'(f);
  endfunction

endpackage

// File: rtl/fltadd_align.sv
// Alignment shifter: loads the smaller significand and a shift count, then
// shifts right one bit per cycle until the count is reached. A zero flag
// loaded alongside forces the output to zero for out-of-range differences.
module fltadd_align
  import fltadd_pkg::*;
#(
  parameter int MW = MANT_W + 1,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          shift,
  input  logic [MW-1:0] m_in,
  input  logic [CW-1:0] k_in,
  input  logic          zero_in,
  output logic [MW-1:0] m_out,
  output logic          last
);

  logic [MW-1:0] sh;
  logic [CW-1:0] cnt;
  logic [CW-1:0] k_q;
  logic          zf;

  // Load on request; otherwise shift while the count has not reached k.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
      k_q <= '0;
      zf  <= 1'b0;
    end else if (load) begin
      sh  <= m_in;
      cnt <= '0;
      k_q <= k_in;
      zf  <= zero_in;
    end else if (shift && (cnt != k_q)) begin
      sh  <= sh >> 1;
      cnt <= cnt + 1'b1;
    end
  end

  // k never exceeds the cap, so cnt+1 cannot wrap before matching.
  assign last  = ((cnt + 1'b1) == k_q);
  assign m_out = zf ? '0 : sh;

endmodule

// File: rtl/fltadd_seq.sv
// Half-precision same-sign adder sequencer: reads two operands from data
// memory, aligns, adds with truncation, writes the sum back, signals done.
module fltadd_seq
  import fltadd_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'd128,
  parameter int         ALIGN_CAP = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data
);

  localparam logic [EXP_W-1:0] CAP5 = EXP_W'(ALIGN_CAP);

  state_t state, nxt;
  logic       armed;
  logic [2:0] rd_cnt;
  logic [7:0] b0, b1, b2;

  logic              l_sign;
  logic [EXP_W-1:0]  l_exp;
  logic [MANT_W:0]   l_mant;
  logic [15:0]       res_q;

  // Operand view on the last read cycle; flt2 low byte comes straight from memory.
  hp_t              f1, f2;
  logic             f1_big;
  logic [EXP_W-1:0] e_l, e_s, diff;
  logic [MANT_W:0]  m_l, m_s;
  logic [3:0]       kval;
  logic             kzero;
  logic             last_rd;

  logic            al_last;
  logic [MANT_W:0] al_m;

  // Unpack, pick larger-exponent operand (tie keeps flt1), clamp shift count.
  always_comb begin
    f1     = unpack({b0, b1});
    f2     = unpack({b2, mem_rd_data});
    f1_big = (f1.exp >= f2.exp);
    e_l    = f1_big ? f1.exp : f2.exp;
    e_s    = f1_big ? f2.exp : f1.exp;
    m_l    = f1_big ? mant(f1) : mant(f2);
    m_s    = f1_big ? mant(f2) : mant(f1);
    diff   = e_l - e_s;
    kzero  = (diff > CAP5);
    kval   = kzero ? CAP5[3:0] : diff[3:0];
  end

  assign last_rd = (state == READ) && (rd_cnt == 3'd4);

  fltadd_align u_align (
    .clk     (clk),
    .reset   (reset),
    .load    (last_rd),
    .shift   (state == ALIGN),
    .m_in    (m_s),
    .k_in    (kval),
    .zero_in (kzero),
    .m_out   (al_m),
    .last    (al_last)
  );

  // Sum, renormalise on carry, saturate to infinity at the top exponent.
  logic [MANT_W+1:0] sum;
  logic [EXP_W:0]    e_sum;
  hp_t               res_c;
  always_comb begin
    sum        = {1'b0, l_mant} + {1'b0, al_m};
    e_sum      = {1'b0, l_exp} + {{EXP_W{1'b0}}, sum[MANT_W+1]};
    res_c.sign = l_sign;
    res_c.exp  = e_sum[EXP_W-1:0];
    res_c.frac = sum[MANT_W+1] ? sum[MANT_W:1] : sum[MANT_W-1:0];
    if (e_sum >= {1'b0, EXP_MAX}) begin
      res_c.exp  = EXP_MAX;
      res_c.frac = '0;
    end
  end

  // Next-state: start high aborts any active run back to IDLE.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (armed && !start) nxt = READ;
      DONE:  if (start) nxt = IDLE;
      default: begin
        if (start) nxt = IDLE;
        else begin
          case (state)
            READ:  if (rd_cnt == 3'd4) nxt = (kval == 4'd0) ? ADD : ALIGN;
            ALIGN: if (al_last) nxt = ADD;
            ADD:   nxt = WR_HI;
            WR_HI: nxt = WR_LO;
            WR_LO: nxt = DONE;
            default: nxt = IDLE;
          endcase
        end
      end
    endcase
  end

  // State, arming, read counter, operand capture, result and done registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      armed  <= 1'b0;
      rd_cnt <= '0;
      b0     <= '0;
      b1     <= '0;
      b2     <= '0;
      l_sign <= 1'b0;
      l_exp  <= '0;
      l_mant <= '0;
      res_q  <= '0;
      done   <= 1'b0;
    end else begin
      state  <= nxt;
      armed  <= (nxt == IDLE) && (start || armed);
      rd_cnt <= (state == READ && nxt == READ) ? rd_cnt + 3'd1 : 3'd0;
      done   <= (nxt == DONE);
      if (state == READ) begin
        case (rd_cnt)
          3'd1: b0 <= mem_rd_data;
          3'd2: b1 <= mem_rd_data;
          3'd3: b2 <= mem_rd_data;
          default: ;
        endcase
      end
      if (last_rd) begin
        l_sign <= f1.sign;
        l_exp  <= e_l;
        l_mant <= m_l;
      end
      if (state == ADD) res_q <= pack(res_c);
    end
  end

  // Memory port driven from the registered state only.
  always_comb begin
    mem_addr    = BASE_ADDR;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      READ:  mem_addr = BASE_ADDR + {6'd0, rd_cnt[1:0]};
      WR_HI: begin
        mem_addr    = BASE_ADDR + 8'd4;
        mem_wr_en   = 1'b1;
        mem_wr_data = res_q[15:8];
      end
      WR_LO: begin
        mem_addr    = BASE_ADDR + 8'd5;
        mem_wr_en   = 1'b1;
        mem_wr_data = res_q[7:0];
      end
      default: ;
    endcase
  end

endmodule
